// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding muxes, PC/IF-ID write gating
// and a saturating stall-cycle counter.
module mips_id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_write_reg_i,
    input  logic              id_RegWrite_i,
    input  logic              id_MemRead_i,
    input  logic              id_MemWrite_i,
    input  logic              id_ALUSrc_i,
    input  logic [3:0]        id_alu_ctrl_i,
    input  logic [1:0]        id_Asrc_i,
    input  logic [1:0]        id_Bsrc_i,
    input  logic [DATA_W-1:0] exmem_alu_result_i,
    input  logic [DATA_W-1:0] memwb_write_data_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ex_valid_o,
    output logic [4:0]        ex_write_reg_o,
    output logic              ex_RegWrite_o,
    output logic              ex_MemRead_o,
    output logic              ex_MemWrite_o,
    output logic [3:0]        ex_alu_ctrl_o,
    output logic [DATA_W-1:0] ex_alu_a_o,
    output logic [DATA_W-1:0] ex_alu_b_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    logic              bubble;
    logic              valid_reg;
    logic              regwrite_reg;
    logic              memread_reg;
    logic              memwrite_reg;
    logic              alusrc_reg;
    logic [4:0]        write_reg_reg;
    logic [3:0]        alu_ctrl_reg;
    logic [1:0]        asrc_reg;
    logic [1:0]        bsrc_reg;
    logic [DATA_W-1:0] rs_data_reg;
    logic [DATA_W-1:0] rt_data_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [CNT_W-1:0]  stall_count_reg;
    logic [CNT_W-1:0]  stall_count_next;

    // Flush only kills the ID instruction; the PC keeps advancing to the new target.
    assign pc_write_o   = ~stall_i;
    assign ifid_write_o = ~stall_i;
    assign bubble       = stall_i | flush_i | ~id_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg     <= 1'b0;
            regwrite_reg  <= 1'b0;
            memread_reg   <= 1'b0;
            memwrite_reg  <= 1'b0;
            alusrc_reg    <= 1'b0;
            write_reg_reg <= '0;
            alu_ctrl_reg  <= '0;
            asrc_reg      <= '0;
            bsrc_reg      <= '0;
            rs_data_reg   <= '0;
            rt_data_reg   <= '0;
            imm_reg       <= '0;
        end else if (bubble) begin
            valid_reg     <= 1'b0;
            regwrite_reg  <= 1'b0;
            memread_reg   <= 1'b0;
            memwrite_reg  <= 1'b0;
            alusrc_reg    <= 1'b0;
            write_reg_reg <= '0;
            alu_ctrl_reg  <= '0;
            asrc_reg      <= '0;
            bsrc_reg      <= '0;
            rs_data_reg   <= '0;
            rt_data_reg   <= '0;
            imm_reg       <= '0;
        end else begin
            valid_reg     <= 1'b1;
            regwrite_reg  <= id_RegWrite_i;
            memread_reg   <= id_MemRead_i;
            memwrite_reg  <= id_MemWrite_i;
            alusrc_reg    <= id_ALUSrc_i;
            write_reg_reg <= id_write_reg_i;
            alu_ctrl_reg  <= id_alu_ctrl_i;
            asrc_reg      <= id_Asrc_i;
            bsrc_reg      <= id_Bsrc_i;
            rs_data_reg   <= id_rs_data_i;
            rt_data_reg   <= id_rt_data_i;
            imm_reg       <= id_imm_i;
        end
    end

    // Saturating increment: hold at all-ones instead of wrapping.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_i && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end

    // Index 0 is the rs/A path, index 1 the rt/B path; select 11 falls back to register data.
    logic [1:0]        fwd_sel  [2];
    logic [DATA_W-1:0] reg_data [2];
    logic [DATA_W-1:0] fwd_data [2];

    assign fwd_sel[0]  = asrc_reg;
    assign fwd_sel[1]  = bsrc_reg;
    assign reg_data[0] = rs_data_reg;
    assign reg_data[1] = rt_data_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_data[gi] = reg_data[gi];
                case (fwd_sel[gi])
                    2'b01:   fwd_data[gi] = exmem_alu_result_i;
                    2'b10:   fwd_data[gi] = memwb_write_data_i;
                    default: fwd_data[gi] = reg_data[gi];
                endcase
            end
        end
    endgenerate

    assign ex_valid_o      = valid_reg;
    assign ex_write_reg_o  = write_reg_reg;
    assign ex_RegWrite_o   = regwrite_reg;
    assign ex_MemRead_o    = memread_reg;
    assign ex_MemWrite_o   = memwrite_reg;
    assign ex_alu_ctrl_o   = alu_ctrl_reg;
    assign ex_alu_a_o      = fwd_data[0];
    assign ex_store_data_o = fwd_data[1];
    assign ex_alu_b_o      = alusrc_reg ? imm_reg : fwd_data[1];
    assign stall_count_o   = stall_count_reg;

endmodule
